uart_tx_frame_gen: RTL



---
 rtl/uart_tx_pkg.sv | 22 ++
 rtl/uart_tx_bit_timer.sv | 42 ++++
 rtl/uart_tx_frame_gen.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/uart_tx_pkg.sv
// Shared types and constants for the UART transmit frame generator.
package uart_tx_pkg;

    // Transmit FSM states, in frame order.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } tx_state_e;

    // Parity_Type encoding.
    localparam logic PAR_EVEN = 1'b0;
    localparam logic PAR_ODD  = 1'b1;

    // Serial line levels.
    localparam logic IDLE_LEVEL  = 1'b1;
    localparam logic START_LEVEL = 1'b0;
    localparam logic STOP_LEVEL  = IDLE_LEVEL;

endpackage : uart_tx_pkg

// File: rtl/uart_tx_bit_timer.sv
// Bit-period timer for the UART transmitter: counts prescaled clock cycles
// within one bit, pulses bit_done on the last cycle of each bit and counts
// completed data bits.
module uart_tx_bit_timer #(
    parameter int PRESCALE_WIDTH = 6,
    parameter int IDX_WIDTH      = 4
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      enable,
    input  logic                      idx_en,
    input  logic [PRESCALE_WIDTH-1:0] prescale_m1,
    output logic                      bit_done,
    output logic [IDX_WIDTH-1:0]      bit_idx
);

    logic [PRESCALE_WIDTH-1:0] count_r;
    logic [IDX_WIDTH-1:0]      idx_r;

    // The wrap cycle is the last cycle of the current bit.
    assign bit_done = enable && (count_r == prescale_m1);
    assign bit_idx  = idx_r;

    // Cycle counter and data-bit index; both held at zero while disabled.
    always_ff @(posedge CLK) begin
        if (RST || !enable) begin
            count_r <= {PRESCALE_WIDTH{1'b0}};
            idx_r   <= {IDX_WIDTH{1'b0}};
        end else if (bit_done) begin
            count_r <= {PRESCALE_WIDTH{1'b0}};
            if (idx_en) begin
                idx_r <= idx_r + {{(IDX_WIDTH-1){1'b0}}, 1'b1};
            end else begin
                idx_r <= idx_r;
            end
        end else begin
            count_r <= count_r + {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};
            idx_r   <= idx_r;
        end
    end

endmodule : uart_tx_bit_timer

// File: rtl/uart_tx_frame_gen.sv
// UART transmit frame generator: serialises one byte per accepted request as
// start bit, LSB-first data, optional parity and one stop bit, each bit held
// for Prescale clock cycles. TX_OUT and Busy are registered.
module uart_tx_frame_gen
    import uart_tx_pkg::*;
#(
    parameter int DATA_WIDTH     = 8,
    parameter int PRESCALE_WIDTH = 6
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic [DATA_WIDTH-1:0]     P_DATA,
    input  logic                      Data_Valid,
    input  logic                      Parity_Enable,
    input  logic                      Parity_Type,
    input  logic [PRESCALE_WIDTH-1:0] Prescale,
    output logic                      TX_OUT,
    output logic                      Busy
);

    localparam int IDX_WIDTH = $clog2(DATA_WIDTH + 1);
    localparam logic [IDX_WIDTH-1:0] LAST_IDX = IDX_WIDTH'(DATA_WIDTH - 1);

    // Parity over the data bits: even = XOR reduction, odd = its inverse.
    function automatic logic calc_parity(input logic [DATA_WIDTH-1:0] data,
                                         input logic                  ptype);
        logic even_bit;
        even_bit = ^data;
        return (ptype == PAR_ODD) ? ~even_bit : even_bit;
    endfunction

    tx_state_e                 state_r;
    tx_state_e                 state_nxt_s;
    logic [DATA_WIDTH-1:0]     shift_r;
    logic                      parity_en_r;
    logic                      parity_bit_r;
    logic [PRESCALE_WIDTH-1:0] presc_m1_r;
    logic [PRESCALE_WIDTH-1:0] presc_m1_s;
    logic                      accept_s;
    logic                      timer_en_s;
    logic                      idx_en_s;
    logic                      bit_done_s;
    logic [IDX_WIDTH-1:0]      bit_idx_s;
    logic                      tx_nxt_s;
    logic                      tx_r;
    logic                      busy_r;

    // Prescale of 0 behaves as 1, so mapping to P-1 never underflows.
    assign presc_m1_s = (Prescale == {PRESCALE_WIDTH{1'b0}})
                      ? {PRESCALE_WIDTH{1'b0}}
                      : Prescale - {{(PRESCALE_WIDTH-1){1'b0}}, 1'b1};

    assign accept_s   = (state_r == IDLE) && Data_Valid;
    assign timer_en_s = (state_r != IDLE);
    assign idx_en_s   = (state_r == DATA);

    uart_tx_bit_timer #(
        .PRESCALE_WIDTH (PRESCALE_WIDTH),
        .IDX_WIDTH      (IDX_WIDTH)
    ) u_bit_timer (
        .CLK         (CLK),
        .RST         (RST),
        .enable      (timer_en_s),
        .idx_en      (idx_en_s),
        .prescale_m1 (presc_m1_r),
        .bit_done    (bit_done_s),
        .bit_idx     (bit_idx_s)
    );

    // FSM state register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic and the line level for the current state.
    always_comb begin
        state_nxt_s = state_r;
        tx_nxt_s    = IDLE_LEVEL;
        case (state_r)
            IDLE: begin
                tx_nxt_s = IDLE_LEVEL;
                if (Data_Valid) begin
                    state_nxt_s = START;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            START: begin
                tx_nxt_s = START_LEVEL;
                if (bit_done_s) begin
                    state_nxt_s = DATA;
                end else begin
                    state_nxt_s = START;
                end
            end
            DATA: begin
                tx_nxt_s = shift_r[0];
                if (bit_done_s && (bit_idx_s == LAST_IDX)) begin
                    state_nxt_s = parity_en_r ? PARITY : STOP;
                end else begin
                    state_nxt_s = DATA;
                end
            end
            PARITY: begin
                tx_nxt_s = parity_bit_r;
                if (bit_done_s) begin
                    state_nxt_s = STOP;
                end else begin
                    state_nxt_s = PARITY;
                end
            end
            STOP: begin
                tx_nxt_s = STOP_LEVEL;
                if (bit_done_s) begin
                    state_nxt_s = IDLE;
                end else begin
                    state_nxt_s = STOP;
                end
            end
            default: begin
                tx_nxt_s    = IDLE_LEVEL;
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Latch the frame-constant settings on accept; shift data out LSB first.
    always_ff @(posedge CLK) begin
        if (RST) begin
            shift_r      <= {DATA_WIDTH{1'b0}};
            parity_en_r  <= 1'b0;
            parity_bit_r <= 1'b0;
            presc_m1_r   <= {PRESCALE_WIDTH{1'b0}};
        end else if (accept_s) begin
            shift_r      <= P_DATA;
            parity_en_r  <= Parity_Enable;
            parity_bit_r <= calc_parity(P_DATA, Parity_Type);
            presc_m1_r   <= presc_m1_s;
        end else if ((state_r == DATA) && bit_done_s) begin
            shift_r      <= {1'b0, shift_r[DATA_WIDTH-1:1]};
        end else begin
            shift_r      <= shift_r;
        end
    end

    // Registered serial line and busy flag; reset forces the line idle.
    always_ff @(posedge CLK) begin
        if (RST) begin
            tx_r   <= IDLE_LEVEL;
            busy_r <= 1'b0;
        end else begin
            tx_r   <= tx_nxt_s;
            busy_r <= (state_r != IDLE);
        end
    end

    assign TX_OUT = tx_r;
    assign Busy   = busy_r;

endmodule : uart_tx_frame_gen
